// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : cache_fill_fsm
//  Description : Miss handler for a direct-mapped cache with 128 sets and
//                16-byte blocks (8 x 16-bit words). On a miss it issues eight
//                back-to-back word reads to memory. It writes each returned
//                word into the data array in order, then writes the tag/valid
//                entry in a single TAG cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk               in   1    clock, rising edge
//    rst               in   1    synchronous reset, active low
//    miss_detected     in   1    miss on miss_address this cycle
//    miss_address      in   16   byte address {tag[15:11], index[10:4], off[3:0]}
//    memory_data_valid in   1    memory_data carries a returned word
//    memory_data       in   16   returned word
//    fsm_busy          out  1    fill in progress, pipeline stalls
//    mem_read_req      out  1    read memory_address this cycle
//    memory_address    out  16   byte address of the word being requested
//    write_data_array  out  1    write data_out at data_word_offset
//    data_word_offset  out  3    word index within the block
//    data_out          out  16   memory_data passed through
//    write_tag_array   out  1    write tag_out into the metadata array
//    tag_out           out  8    {valid, 2'b00, tag}
//    block_enable      out  128  one-hot set select
// ============================================================================
module cache_fill_fsm (
    input  logic         clk,
    input  logic         rst,
    input  logic         miss_detected,
    input  logic [15:0]  miss_address,
    input  logic         memory_data_valid,
    input  logic [15:0]  memory_data,
    output logic         fsm_busy,
    output logic         mem_read_req,
    output logic [15:0]  memory_address,
    output logic         write_data_array,
    output logic [2:0]   data_word_offset,
    output logic [15:0]  data_out,
    output logic         write_tag_array,
    output logic [7:0]   tag_out,
    output logic [127:0] block_enable
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  issue_cnt_q, issue_cnt_d;
    logic [3:0]  ret_cnt_q, ret_cnt_d;
    logic [15:0] base_addr_q, base_addr_d;

    always_comb begin
        state_d          = state_q;
        issue_cnt_d      = issue_cnt_q;
        ret_cnt_d        = ret_cnt_q;
        base_addr_d      = base_addr_q;
        fsm_busy         = 1'b0;
        mem_read_req     = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        // While filling, the set select follows the latched block so the
        // pipeline's current address cannot redirect the array writes.
        block_enable     = 128'd1 << base_addr_q[10:4];

        case (state_q)
            IDLE: begin
                // Metadata array stays in read mode for the hit/miss lookup.
                block_enable = 128'd1 << miss_address[10:4];
                if (miss_detected) begin
                    // Masking keeps the block-aligned base without leaving
                    // the offset bits dangling.
                    base_addr_d = miss_address & 16'hFFF0;
                    issue_cnt_d = 4'd0;
                    ret_cnt_d   = 4'd0;
                    state_d     = FILL;
                end
            end

            FILL: begin
                fsm_busy = 1'b1;
                if (issue_cnt_q < 4'd8) begin
                    mem_read_req = 1'b1;
                    issue_cnt_d  = issue_cnt_q + 4'd1;
                end
                // Only accept a return when a request is outstanding; a
                // stray strobe must not advance the word offset.
                if (memory_data_valid && (ret_cnt_q < issue_cnt_q)) begin
                    write_data_array = 1'b1;
                    ret_cnt_d        = ret_cnt_q + 4'd1;
                    if (ret_cnt_q == 4'd7) begin
                        state_d = TAG;
                    end
                end
            end

            TAG: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                state_d         = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Word-addressed request stream: each word is two bytes past the last.
    assign memory_address   = base_addr_q + {12'd0, issue_cnt_q[2:0], 1'b0};
    assign data_word_offset = ret_cnt_q[2:0];
    assign data_out         = memory_data;
    assign tag_out          = {1'b1, 2'b00, base_addr_q[15:11]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= 4'd0;
            ret_cnt_q   <= 4'd0;
            base_addr_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            base_addr_q <= base_addr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_fill_fsm
//  Description : Directed self-checking bench for cache_fill_fsm.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;

    logic         clk;
    logic         rst;
    logic         miss_detected;
    logic [15:0]  miss_address;
    logic         memory_data_valid;
    logic [15:0]  memory_data;
    logic         fsm_busy;
    logic         mem_read_req;
    logic [15:0]  memory_address;
    logic         write_data_array;
    logic [2:0]   data_word_offset;
    logic [15:0]  data_out;
    logic         write_tag_array;
    logic [7:0]   tag_out;
    logic [127:0] block_enable;

    int n_cmp;
    int n_fail;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_read_req      (mem_read_req),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .data_word_offset  (data_word_offset),
        .data_out          (data_out),
        .write_tag_array   (write_tag_array),
        .tag_out           (tag_out),
        .block_enable      (block_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are then changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [127:0] exp_be;
        rst = 1'b0;
        miss_detected = 1'b0;
        miss_address = 16'h0000;
        memory_data_valid = 1'b0;
        memory_data = 16'h0000;
        step();
        step();
        rst = 1'b1;
        #1;
        exp_be = 128'd1;
        n_cmp++; if (fsm_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", fsm_busy); end
        n_cmp++; if (mem_read_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", mem_read_req); end
        n_cmp++; if (write_data_array !== 1'b0) begin n_fail++; $display("FAIL reset_wda got=%b exp=0", write_data_array); end
        n_cmp++; if (write_tag_array !== 1'b0) begin n_fail++; $display("FAIL reset_wta got=%b exp=0", write_tag_array); end
        n_cmp++; if (memory_address !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got=%h exp=0000", memory_address); end
        n_cmp++; if (data_word_offset !== 3'd0) begin n_fail++; $display("FAIL reset_off got=%0d exp=0", data_word_offset); end
        n_cmp++; if (tag_out !== 8'h80) begin n_fail++; $display("FAIL reset_tag got=%h exp=80", tag_out); end
        n_cmp++; if (block_enable !== exp_be) begin n_fail++; $display("FAIL reset_be got=%h exp=%h", block_enable, exp_be); end
    endtask

    // Present a one-cycle miss in IDLE; on return the DUT is in the first
    // FILL cycle.
    task automatic start_miss(input logic [15:0] addr, input int exp_idx);
        logic [127:0] exp_be;
        exp_be = 128'd1 << exp_idx;
        miss_detected = 1'b1;
        miss_address = addr;
        #1;
        n_cmp++; if (fsm_busy !== 1'b0) begin n_fail++; $display("FAIL miss_idle_busy got=%b exp=0", fsm_busy); end
        n_cmp++; if (write_tag_array !== 1'b0) begin n_fail++; $display("FAIL miss_idle_wta got=%b exp=0", write_tag_array); end
        n_cmp++; if (block_enable !== exp_be) begin n_fail++; $display("FAIL miss_idle_be got=%h exp=%h", block_enable, exp_be); end
        step();
        miss_detected = 1'b0;
    endtask

    // Drive a complete fill from the first FILL cycle (c=0). Word k returns
    // at cycle 4 + spacing*k. Optionally pulse a foreign miss at c=2, or
    // raise a miss from the TAG cycle onward (left asserted on exit).
    task automatic run_fill(input logic [15:0] base, input int idx, input logic [7:0] exp_tag,
                            input int spacing, input bit glitch, input bit tag_miss,
                            input logic [15:0] addr2, input int idx2);
        int last;
        int k;
        bit is_ret;
        logic [127:0] exp_be;
        logic [127:0] exp_be2;
        last = 4 + spacing * 7;
        exp_be = 128'd1 << idx;
        exp_be2 = 128'd1 << idx2;
        for (int c = 0; c <= last + 2; c++) begin
            is_ret = (c >= 4) && (((c - 4) % spacing) == 0) && (((c - 4) / spacing) < 8);
            k = (c - 4) / spacing;
            memory_data_valid = is_ret;
            memory_data = is_ret ? (16'hD000 | 16'(k)) : 16'h0BAD;
            if (tag_miss && c >= last + 1) begin
                miss_detected = 1'b1;
                miss_address = addr2;
            end else if (glitch && c == 2) begin
                miss_detected = 1'b1;
                miss_address = 16'hFFF0;
            end else begin
                miss_detected = 1'b0;
            end
            #1;
            n_cmp++; if (fsm_busy !== (c <= last + 1)) begin n_fail++; $display("FAIL fill_busy c=%0d got=%b", c, fsm_busy); end
            n_cmp++; if (mem_read_req !== (c < 8)) begin n_fail++; $display("FAIL fill_req c=%0d got=%b", c, mem_read_req); end
            if (c < 8) begin
                n_cmp++; if (memory_address !== base + 16'(2 * c)) begin n_fail++; $display("FAIL fill_addr c=%0d got=%h exp=%h", c, memory_address, base + 16'(2 * c)); end
            end
            n_cmp++; if (write_data_array !== is_ret) begin n_fail++; $display("FAIL fill_wda c=%0d got=%b exp=%b", c, write_data_array, is_ret); end
            if (is_ret) begin
                n_cmp++; if (data_word_offset !== 3'(k)) begin n_fail++; $display("FAIL fill_off c=%0d got=%0d exp=%0d", c, data_word_offset, k); end
                n_cmp++; if (data_out !== (16'hD000 | 16'(k))) begin n_fail++; $display("FAIL fill_data c=%0d got=%h", c, data_out); end
            end
            n_cmp++; if (write_tag_array !== (c == last + 1)) begin n_fail++; $display("FAIL fill_wta c=%0d got=%b", c, write_tag_array); end
            if (c <= last + 1) begin
                n_cmp++; if (block_enable !== exp_be) begin n_fail++; $display("FAIL fill_be c=%0d got=%h exp=%h", c, block_enable, exp_be); end
            end
            if (c == last + 1) begin
                n_cmp++; if (tag_out !== exp_tag) begin n_fail++; $display("FAIL fill_tag got=%h exp=%h", tag_out, exp_tag); end
            end
            if (tag_miss && c == last + 2) begin
                n_cmp++; if (block_enable !== exp_be2) begin n_fail++; $display("FAIL tagmiss_idle_be got=%h exp=%h", block_enable, exp_be2); end
            end
            step();
        end
        memory_data_valid = 1'b0;
    endtask

    task automatic test_fill_latency4();
        start_miss(16'hABCD, 60);
        run_fill(16'hABC0, 60, 8'h95, 1, 1'b0, 1'b0, 16'h0000, 0);
    endtask

    task automatic test_fill_gaps();
        start_miss(16'h5A38, 35);
        run_fill(16'h5A30, 35, 8'h8B, 2, 1'b0, 1'b0, 16'h0000, 0);
    endtask

    task automatic test_spurious();
        memory_data_valid = 1'b1;
        memory_data = 16'hEEEE;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (write_data_array !== 1'b0) begin n_fail++; $display("FAIL idle_valid_wda i=%0d got=%b exp=0", i, write_data_array); end
            n_cmp++; if (fsm_busy !== 1'b0) begin n_fail++; $display("FAIL idle_valid_busy i=%0d got=%b exp=0", i, fsm_busy); end
            step();
        end
        memory_data_valid = 1'b0;
        start_miss(16'h1234, 35);
        run_fill(16'h1230, 35, 8'h82, 1, 1'b1, 1'b0, 16'h0000, 0);
    endtask

    task automatic test_reset_mid_fill();
        start_miss(16'hABCD, 60);
        for (int c = 0; c <= 6; c++) begin
            memory_data_valid = (c >= 4);
            memory_data = 16'hD000 | 16'(c - 4);
            #1;
            if (c == 6) begin
                n_cmp++; if (write_data_array !== 1'b1 || data_word_offset !== 3'd2) begin n_fail++; $display("FAIL abort_third wda=%b off=%0d exp=1/2", write_data_array, data_word_offset); end
            end
            step();
        end
        memory_data_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        miss_address = 16'h0000;
        #1;
        n_cmp++; if (fsm_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", fsm_busy); end
        n_cmp++; if (mem_read_req !== 1'b0) begin n_fail++; $display("FAIL abort_req got=%b exp=0", mem_read_req); end
        n_cmp++; if (memory_address !== 16'h0000) begin n_fail++; $display("FAIL abort_addr got=%h exp=0000", memory_address); end
        n_cmp++; if (data_word_offset !== 3'd0) begin n_fail++; $display("FAIL abort_off got=%0d exp=0", data_word_offset); end
        n_cmp++; if (tag_out !== 8'h80) begin n_fail++; $display("FAIL abort_tag got=%h exp=80", tag_out); end
        for (int i = 0; i < 5; i++) begin
            memory_data_valid = 1'b1;
            memory_data = 16'hD003 + 16'(i);
            #1;
            n_cmp++; if (write_data_array !== 1'b0 || write_tag_array !== 1'b0) begin n_fail++; $display("FAIL abort_late_ret i=%0d wda=%b wta=%b exp=0/0", i, write_data_array, write_tag_array); end
            step();
        end
        memory_data_valid = 1'b0;
        start_miss(16'h0010, 1);
        run_fill(16'h0010, 1, 8'h80, 1, 1'b0, 1'b0, 16'h0000, 0);
    endtask

    task automatic test_back_to_back();
        // 0x2468: tag 00100 -> 8'h84, index 0x46 = 70; next block 0x7770:
        // tag 01110 -> 8'h8E, index 0x77 = 119.
        start_miss(16'h2468, 70);
        run_fill(16'h2460, 70, 8'h84, 1, 1'b0, 1'b1, 16'h7777, 119);
        // run_fill stepped past the IDLE cycle with the miss still held.
        miss_detected = 1'b0;
        #1;
        n_cmp++; if (fsm_busy !== 1'b1 || mem_read_req !== 1'b1) begin n_fail++; $display("FAIL b2b_start busy=%b req=%b exp=1/1", fsm_busy, mem_read_req); end
        run_fill(16'h7770, 119, 8'h8E, 1, 1'b0, 1'b0, 16'h0000, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_fill_latency4();
        test_fill_gaps();
        test_spurious();
        test_reset_mid_fill();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
